vga_frame_sequencer: RTL and testbench
======================================

Name: vga_frame_sequencer

Overview:
Master VGA timing controller for the display path. Divides the system clock into a pixel tick and runs the horizontal (pixel) and vertical (line) counters. Decodes hsync/vsync/video_on and frame-event pulses from those counters. Also arbitrates one update window per frame: game-state logic requests a window and is granted it only during vertical blank, so sprite and pipe state never change mid-scan.

Parameters:
DW, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
DIV, 2, system clocks per pixel tick (>=1)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum of the four H_* values = 800
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = 525

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  run; low freezes the divider, counters and arbiter
pix_tick  out  1  one-clk pulse every DIV clocks while enable=1
h_count  out  DW  pixel counter, 0..H_TOTAL-1
v_count  out  DW  line counter, 0..V_TOTAL-1
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
video_on  out  1  high while inside the active area and running
frame_start  out  1  one-clk pulse when the counters wrap to (0,0)
vblank_start  out  1  one-clk pulse when v_count becomes V_ACTIVE (h_count=0)
upd_req  in  1  update window request from game logic (level)
upd_grant  out  1  update window granted (level)
upd_overrun  out  1  one-clk pulse when an active grant is revoked by frame_start

Behaviour:
- One clock domain (clk). rst is asynchronous and active-high.
- Reset values:
  - div counter, h_count, v_count = 0
  - running = 0
  - hsync = vsync = 1
  - video_on, pix_tick, frame_start, vblank_start, upd_grant, upd_overrun = 0
  - arbiter state = G_IDLE
- running: set on the first clk with enable=1 and never cleared except by rst.
- Divider: counts 0..DIV-1 while enable=1. pix_tick=1 in the cycle it holds DIV-1; it wraps to 0 on the next edge. With DIV=1, pix_tick is high on every enabled cycle.
- Counter advance: on an edge with enable && pix_tick, h_count increments.
  - At H_TOTAL-1, h_count wraps to 0 and v_count increments.
  - At v_count V_TOTAL-1 with that h wrap, v_count wraps to 0.
  - enable=0: all registers hold. A pending pix_tick stays asserted but does not advance the counters.
- Decoded outputs are registered and aligned with the counters (they update on the same edge, computed from next-count values):
  - hsync=0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751
  - vsync=0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491
  - video_on=1 iff running && h<H_ACTIVE && v<V_ACTIVE
  - While running=0, hsync=vsync=1 and video_on=0.
- Event pulses last exactly one clk and coincide with the first clk showing the new counts:
  - frame_start: counts become (0,0) via wrap. It does not fire at reset.
  - vblank_start: counts become (0, V_ACTIVE).
- Arbiter FSM, evaluated every enabled clk:
  - inblank = v_count >= V_ACTIVE (current count).
  - G_IDLE: if upd_req && inblank -> G_GRANT; if upd_req && !inblank -> G_WAIT.
  - G_WAIT: if upd_req drops -> G_IDLE; if inblank -> G_GRANT.
  - G_GRANT: upd_grant=1 (registered; asserted the clk after entry).
    - If upd_req drops -> G_DONE, and upd_grant drops on the next edge.
    - On a frame_start pulse with upd_req still high -> G_WAIT, upd_grant=0 on the next edge, upd_overrun pulses once.
    - If both happen in the same cycle, the drop takes priority: -> G_DONE, no overrun.
  - G_DONE: ignores upd_req and returns to G_IDLE on frame_start. This enforces at most one grant window per frame.
- Latency: request in blank -> upd_grant 1 clk later. Request in active video -> grant 1 clk after the vblank_start pulse.
- Reset asserted mid-frame or mid-grant: all state returns to reset values immediately (asynchronously). upd_grant drops without an overrun pulse.

Test Plan:
1. Reset, enable=1, DIV=2: pix_tick pulses every 2nd clk. After 1600 clks, h_count=0 and v_count=1. hsync low exactly for h=656..751 (96 ticks).
2. Run a full frame (800*525 ticks): one frame_start at wrap to (0,0). vsync low for lines 490..491 only. vblank_start fires at (0,480). video_on high for exactly 640*480 ticks.
3. Drop enable for 37 clks at h=655: counters, hsync and pix_tick hold. On resume, hsync falls on the next tick as h reaches 656.
4. Raise upd_req at v=100: no grant through line 479. upd_grant=1 one clk after vblank_start. Drop upd_req at v=500: grant=0 next clk. Raise upd_req again at v=510: no grant until after the next frame_start.
5. Hold upd_req high through a wrap: upd_grant falls with frame_start, upd_overrun pulses once, and the grant reasserts after the next vblank_start. Drop upd_req in the same clk as frame_start: no overrun.
6. Assert rst mid-grant at (300,495): all outputs return to reset values within the same cycle. No pulses before enable, and no frame_start at restart.

Source files
------------

// File: rtl/vga_frame_sequencer_if.sv
// vga_frame_sequencer_if: run control, timing outputs and update-window handshake of the frame sequencer
interface vga_frame_sequencer_if #(parameter int DW = 10);
  logic enable;
  logic pix_tick;
  logic [DW-1:0] h_count;
  logic [DW-1:0] v_count;
  logic hsync;
  logic vsync;
  logic video_on;
  logic frame_start;
  logic vblank_start;
  logic upd_req;
  logic upd_grant;
  logic upd_overrun;
  modport master (
    input  enable, upd_req,
    output pix_tick, h_count, v_count, hsync, vsync, video_on,
           frame_start, vblank_start, upd_grant, upd_overrun
  );
  modport slave (
    output enable, upd_req,
    input  pix_tick, h_count, v_count, hsync, vsync, video_on,
           frame_start, vblank_start, upd_grant, upd_overrun
  );
endinterface

// File: rtl/vga_frame_sequencer.sv
// vga_frame_sequencer: VGA pixel/line timing plus a once-per-frame vblank update-window arbiter
module vga_frame_sequencer #(
  parameter int DW       = 10,
  parameter int DIV      = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input logic clk,
  input logic rst,
  vga_frame_sequencer_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DVW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [DVW-1:0] DMAX = DVW'(DIV - 1);
  localparam logic [DW-1:0] HMAX = DW'(H_TOTAL - 1);
  localparam logic [DW-1:0] VMAX = DW'(V_TOTAL - 1);
  localparam logic [DW-1:0] HA   = DW'(H_ACTIVE);
  localparam logic [DW-1:0] VA   = DW'(V_ACTIVE);
  localparam logic [DW-1:0] VLST = DW'(V_ACTIVE - 1);
  localparam logic [DW-1:0] HS0  = DW'(H_ACTIVE + H_FP);
  localparam logic [DW-1:0] HS1  = DW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [DW-1:0] VS0  = DW'(V_ACTIVE + V_FP);
  localparam logic [DW-1:0] VS1  = DW'(V_ACTIVE + V_FP + V_SYNC);
  typedef enum logic [1:0] {G_IDLE, G_WAIT, G_GRANT, G_DONE} gst_t;
  logic [DVW-1:0] div, div_nxt;
  logic [DW-1:0] h, v, h_nxt, v_nxt;
  logic running, run_nxt, adv, h_wrap, inblank, grant_nxt, ov_nxt;
  gst_t st, st_nxt;
  assign bus.pix_tick = running && div == DMAX;
  assign bus.h_count  = h;
  assign bus.v_count  = v;
  always_comb begin
    adv     = bus.enable && bus.pix_tick;
    h_wrap  = h == HMAX;
    run_nxt = running | bus.enable;
    div_nxt = !bus.enable ? div : (div == DMAX) ? '0 : div + 1'b1;
    h_nxt   = !adv ? h : h_wrap ? '0 : h + 1'b1;
    v_nxt   = !(adv && h_wrap) ? v : (v == VMAX) ? '0 : v + 1'b1;
  end
  // decodes are taken from the next counts so they line up with the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div              <= '0;
      h                <= '0;
      v                <= '0;
      running          <= 1'b0;
      bus.hsync        <= 1'b1;
      bus.vsync        <= 1'b1;
      bus.video_on     <= 1'b0;
      bus.frame_start  <= 1'b0;
      bus.vblank_start <= 1'b0;
    end else begin
      div              <= div_nxt;
      h                <= h_nxt;
      v                <= v_nxt;
      running          <= run_nxt;
      bus.hsync        <= !(run_nxt && h_nxt >= HS0 && h_nxt < HS1);
      bus.vsync        <= !(run_nxt && v_nxt >= VS0 && v_nxt < VS1);
      bus.video_on     <= run_nxt && h_nxt < HA && v_nxt < VA;
      bus.frame_start  <= adv && h_wrap && v == VMAX;
      bus.vblank_start <= adv && h_wrap && v == VLST;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st              <= G_IDLE;
      bus.upd_grant   <= 1'b0;
      bus.upd_overrun <= 1'b0;
    end else begin
      st              <= st_nxt;
      bus.upd_grant   <= grant_nxt;
      bus.upd_overrun <= ov_nxt;
    end
  end
  always_comb begin
    inblank = v >= VA;
    st_nxt  = st;
    if (bus.enable)
      case (st)
        G_IDLE, G_WAIT: st_nxt = !bus.upd_req ? G_IDLE : inblank ? G_GRANT : G_WAIT;
        G_GRANT:        st_nxt = !bus.upd_req ? G_DONE : bus.frame_start ? G_WAIT : G_GRANT;
        default:        st_nxt = bus.frame_start ? G_IDLE : G_DONE;
      endcase
  end
  // a request drop wins over a simultaneous frame wrap, so no overrun then
  always_comb begin
    grant_nxt = st_nxt == G_GRANT;
    ov_nxt    = bus.enable && st == G_GRANT && bus.upd_req && bus.frame_start;
  end
endmodule

// File: tb/tb_vga_frame_sequencer.sv
// tb_vga_frame_sequencer: directed and random checks of the frame sequencer against an arithmetic timing model
module tb_vga_frame_sequencer;
  localparam int DIV = 2;
  localparam int HA = 8, HFP = 2, HS = 3, HB = 3;
  localparam int VA = 6, VFP = 2, VS = 2, VB = 2;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;
  localparam int FR = HT * VT;
  localparam int M_IDLE = 0, M_WAIT = 1, M_GRANT = 2, M_DONE = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  vga_frame_sequencer_if #(.DW(10)) bus();
  vga_frame_sequencer #(
    .DW(10), .DIV(DIV),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int n, st;
  bit last_en, m_grant, m_ov;
  bit req_r;
  function automatic int ticks(); return n / DIV; endfunction
  function automatic int mh(); return ticks() % HT; endfunction
  function automatic int mv(); return (ticks() / HT) % VT; endfunction
  function automatic bit m_pix(); return n > 0 && n % DIV == DIV - 1; endfunction
  function automatic bit m_adv(); return last_en && n > 0 && n % DIV == 0; endfunction
  function automatic bit m_fs(); return m_adv() && ticks() % FR == 0; endfunction
  function automatic bit m_vb(); return m_adv() && ticks() % FR == VA * HT; endfunction
  function automatic bit m_hs(); return !(n > 0 && mh() >= HA + HFP && mh() < HA + HFP + HS); endfunction
  function automatic bit m_vs(); return !(n > 0 && mv() >= VA + VFP && mv() < VA + VFP + VS); endfunction
  function automatic bit m_vid(); return n > 0 && mh() < HA && mv() < VA; endfunction
  task automatic reset_model();
    n = 0; st = M_IDLE; last_en = 0; m_grant = 0; m_ov = 0;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d (model n=%0d h=%0d v=%0d)", tag, got, exp, n, mh(), mv());
    end
  endtask
  task automatic check_all();
    chk("pix_tick", 32'(bus.pix_tick), 32'(m_pix()));
    chk("h_count", 32'(bus.h_count), 32'(mh()));
    chk("v_count", 32'(bus.v_count), 32'(mv()));
    chk("hsync", 32'(bus.hsync), 32'(m_hs()));
    chk("vsync", 32'(bus.vsync), 32'(m_vs()));
    chk("video_on", 32'(bus.video_on), 32'(m_vid()));
    chk("frame_start", 32'(bus.frame_start), 32'(m_fs()));
    chk("vblank_start", 32'(bus.vblank_start), 32'(m_vb()));
    chk("upd_grant", 32'(bus.upd_grant), 32'(m_grant));
    chk("upd_overrun", 32'(bus.upd_overrun), 32'(m_ov));
  endtask
  // one window per frame: granted in blank, revoked by a wrap while still requested
  task automatic model_edge(input bit en, input bit req);
    bit fs_now, blank;
    fs_now = m_fs();
    blank = mv() >= VA;
    if (en) begin
      m_ov = st == M_GRANT && req && fs_now;
      if (st == M_IDLE || st == M_WAIT) st = !req ? M_IDLE : blank ? M_GRANT : M_WAIT;
      else if (st == M_GRANT) st = !req ? M_DONE : fs_now ? M_WAIT : M_GRANT;
      else if (fs_now) st = M_IDLE;
      m_grant = st == M_GRANT;
      n++;
    end else m_ov = 0;
    last_en = en;
  endtask
  task automatic cyc(input bit en, input bit req);
    bus.enable = en;
    bus.upd_req = req;
    @(posedge clk);
    model_edge(en, req);
    @(negedge clk);
    check_all();
  endtask
  task automatic run_to(input int th, input int tv, input bit req);
    int k;
    k = 0;
    while (!(mh() == th && mv() == tv) && k < 2 * DIV * FR + 4) begin
      cyc(1, req);
      k++;
    end
    chk("reach_target", 32'(bus.h_count == 10'(th) && bus.v_count == 10'(tv)), 32'd1);
  endtask
  initial begin
    bus.enable = 0;
    bus.upd_req = 0;
    reset_model();
    #12;
    check_all();
    @(negedge clk);
    rst = 0;
    repeat (4) cyc(0, 1);
    // two full lines then a full frame with no requests
    repeat (2 * HT * DIV) cyc(1, 0);
    chk("after_two_lines_h", 32'(bus.h_count), 32'd0);
    chk("after_two_lines_v", 32'(bus.v_count), 32'd2);
    run_to(0, 0, 0);
    run_to(0, 2, 0);
    // freeze just before the hsync pulse
    run_to(HA + HFP - 1, 2, 0);
    cyc(1, 0);
    repeat (37) cyc(0, 0);
    chk("frozen_pix", 32'(bus.pix_tick), 32'd1);
    chk("frozen_hsync", 32'(bus.hsync), 32'd1);
    cyc(1, 0);
    chk("resume_hsync_fall", 32'(bus.hsync), 32'd0);
    chk("resume_h", 32'(bus.h_count), 32'(HA + HFP));
    // request during active video, granted after vblank_start
    run_to(0, 1, 0);
    run_to(0, VA, 1);
    chk("no_grant_at_vb", 32'(bus.upd_grant), 32'd0);
    cyc(1, 1);
    chk("grant_after_vb", 32'(bus.upd_grant), 32'd1);
    run_to(0, VA + 2, 1);
    cyc(1, 0);
    chk("grant_drop", 32'(bus.upd_grant), 32'd0);
    run_to(0, VA + 4, 0);
    run_to(0, 0, 1);
    chk("done_no_regrant", 32'(bus.upd_grant), 32'd0);
    run_to(0, VA, 1);
    cyc(1, 1);
    chk("regrant_next_frame", 32'(bus.upd_grant), 32'd1);
    // request held through a wrap: overrun
    run_to(0, 0, 1);
    cyc(1, 1);
    chk("overrun_pulse", 32'(bus.upd_overrun), 32'd1);
    chk("overrun_grant_low", 32'(bus.upd_grant), 32'd0);
    cyc(1, 1);
    chk("overrun_single", 32'(bus.upd_overrun), 32'd0);
    run_to(0, VA, 1);
    cyc(1, 1);
    chk("grant_after_overrun", 32'(bus.upd_grant), 32'd1);
    // drop in the frame_start cycle: no overrun
    run_to(0, 0, 1);
    cyc(1, 0);
    chk("drop_at_fs_no_ovr", 32'(bus.upd_overrun), 32'd0);
    chk("drop_at_fs_grant", 32'(bus.upd_grant), 32'd0);
    // random enable gaps and request toggles
    req_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) req_r = !req_r;
      cyc($urandom_range(0, 7) != 0, req_r);
    end
    // async reset in the middle of a grant
    for (int i = 0; i < 2 * DIV * FR && !(m_grant && mv() > VA); i++) cyc(1, 1);
    chk("grant_before_rst", 32'(bus.upd_grant), 32'd1);
    #2 rst = 1;
    #1 reset_model();
    check_all();
    @(negedge clk);
    rst = 0;
    repeat (5) cyc(0, 1);
    repeat (3 * HT * DIV) cyc(1, $urandom_range(0, 1) == 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
